// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes and debounces the A/B channels, then tracks
// the filtered pair with a small FSM that emits step/dir pulses, keeps a
// wrapping up/down position count and flags illegal two-channel jumps.
module quad_decoder #(
  parameter int FILT_CYCLES = 4,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clear,
  output logic             step,
  output logic             dir,
  output logic [CNT_W-1:0] position,
  output logic             err
);

  // Settle time lets both synchronizers and filters flush before tracking.
  localparam int         SETTLE      = 2 * FILT_CYCLES + 4;
  localparam logic [7:0] FILT_LAST   = 8'(FILT_CYCLES - 1);
  localparam logic [9:0] SETTLE_LAST = 10'(SETTLE - 1);

  typedef enum logic [2:0] {INIT, S00, S10, S11, S01} state_t;

  // Bit 1 is channel A, bit 0 is channel B throughout.
  logic [1:0] raw;
  logic [1:0] filt;
  logic [1:0] filt_nx;

  assign raw = {a_in, b_in};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic       sync1_reg;
      logic       sync2_reg;
      logic       filt_reg;
      logic       filt_next;
      logic [7:0] cnt_reg;
      logic [7:0] cnt_next;

      // Two-flop synchronizer followed by the debounce state of this channel.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          filt_reg  <= 1'b0;
          cnt_reg   <= 8'd0;
        end else begin
          sync1_reg <= raw[gi];
          sync2_reg <= sync1_reg;
          filt_reg  <= filt_next;
          cnt_reg   <= cnt_next;
        end
      end

      // Count consecutive disagreeing cycles; toggle once the run is long enough.
      always_comb begin
        filt_next = filt_reg;
        cnt_next  = 8'd0;
        if (sync2_reg != filt_reg) begin
          if (cnt_reg == FILT_LAST) begin
            filt_next = ~filt_reg;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
      end

      assign filt[gi]    = filt_reg;
      assign filt_nx[gi] = filt_next;
    end
  endgenerate

  function automatic state_t pair_state(input logic [1:0] ab);
    case (ab)
      2'b00:   return S00;
      2'b10:   return S10;
      2'b11:   return S11;
      default: return S01;
    endcase
  endfunction

  // Position of a state along the up sequence 00->10->11->01.
  function automatic logic [1:0] seq_idx(input state_t s);
    case (s)
      S10:     return 2'd1;
      S11:     return 2'd2;
      S01:     return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  state_t           state_reg, state_next;
  state_t           new_state;
  logic [9:0]       settle_reg, settle_next;
  logic [1:0]       up_idx;
  logic             step_next;
  logic             dir_next;
  logic [CNT_W-1:0] pos_next;
  logic             err_next;

  // FSM state, settle counter and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= INIT;
      settle_reg <= 10'd0;
      step       <= 1'b0;
      dir        <= 1'b1;
      position   <= '0;
      err        <= 1'b0;
    end else begin
      state_reg  <= state_next;
      settle_reg <= settle_next;
      step       <= step_next;
      dir        <= dir_next;
      position   <= pos_next;
      err        <= err_next;
    end
  end

  // Decode the filtered pair change landing on this edge into step/err.
  always_comb begin
    state_next  = state_reg;
    settle_next = settle_reg;
    step_next   = 1'b0;
    dir_next    = dir;
    pos_next    = position;
    err_next    = err;
    new_state   = pair_state(filt_nx);
    up_idx      = seq_idx(state_reg) + 2'd1;

    if (state_reg == INIT) begin
      if (settle_reg == SETTLE_LAST) begin
        state_next = new_state;
      end else begin
        settle_next = settle_reg + 10'd1;
      end
    end else if (new_state != state_reg) begin
      state_next = new_state;
      if ((filt_nx ^ filt) == 2'b11) begin
        err_next = 1'b1;
      end else begin
        step_next = 1'b1;
        if (seq_idx(new_state) == up_idx) begin
          dir_next = 1'b1;
          pos_next = position + CNT_W'(1);
        end else begin
          dir_next = 1'b0;
          pos_next = position - CNT_W'(1);
        end
      end
    end

    // Clear takes priority over any count or error update on the same edge.
    if (clear) begin
      pos_next = '0;
      err_next = 1'b0;
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder with FILT_CYCLES=4, CNT_W=4.
module tb_quad_decoder;

  logic       clk;
  logic       reset;
  logic       a_in;
  logic       b_in;
  logic       clear;
  logic       step;
  logic       dir;
  logic [3:0] position;
  logic       err;

  int total_cnt = 0;
  int pass_cnt  = 0;

  quad_decoder #(.FILT_CYCLES(4), .CNT_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .a_in     (a_in),
    .b_in     (b_in),
    .clear    (clear),
    .step     (step),
    .dir      (dir),
    .position (position),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Sample for n falling edges, counting step pulses and the first pulse cycle.
  task automatic run(input int n, output int nsteps, output int first);
    nsteps = 0;
    first  = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (step === 1'b1) begin
        nsteps++;
        if (first == 0) first = k;
      end
    end
  endtask

  // Drive a new pin pair at a falling edge and observe for hold cycles.
  task automatic move(input logic [1:0] ab, input int hold, input int exp_steps,
                      input logic [3:0] exp_pos, input string tag);
    int ns, fs;
    a_in = ab[1];
    b_in = ab[0];
    run(hold, ns, fs);
    $display("move %s ab=%b steps=%0d first=%0d pos=%0d dir=%0d err=%0d",
             tag, ab, ns, fs, position, dir, err);
    check({tag, "_steps"}, ns, exp_steps);
    if (exp_steps == 1) check({tag, "_lat"}, fs, 6);
    check({tag, "_pos"}, position, exp_pos);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    int ns, fs;
    reset = 1'b1;
    a_in  = 1'b0;
    b_in  = 1'b0;
    clear = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_step", step, 0);
    check("rst_dir", dir, 1);
    check("rst_pos", position, 0);
    check("rst_err", err, 0);
    reset = 1'b0;

    // Idle after reset: no activity at all.
    move(2'b00, 30, 0, 4'd0, "idle");
    check("idle_err", err, 0);
    check("idle_dir", dir, 1);

    // One full up cycle.
    move(2'b10, 10, 1, 4'd1, "up1");
    move(2'b11, 10, 1, 4'd2, "up2");
    move(2'b01, 10, 1, 4'd3, "up3");
    move(2'b00, 10, 1, 4'd4, "up4");
    check("up_dir", dir, 1);

    pulse_clear();
    check("clr_pos", position, 0);

    // Down cycle from zero wraps through 15.
    move(2'b01, 10, 1, 4'd15, "dn1");
    move(2'b11, 10, 1, 4'd14, "dn2");
    move(2'b10, 10, 1, 4'd13, "dn3");
    move(2'b00, 10, 1, 4'd12, "dn4");
    check("dn_dir", dir, 0);
    check("dn_err", err, 0);

    // Glitch of 3 cycles on A is rejected.
    a_in = 1'b1;
    repeat (3) @(negedge clk);
    a_in = 1'b0;
    run(12, ns, fs);
    $display("glitch3 steps=%0d pos=%0d", ns, position);
    check("g3_steps", ns, 0);
    check("g3_pos", position, 12);

    // 4-cycle pulse on A is accepted: up on rise, down on fall.
    a_in = 1'b1;
    repeat (4) @(negedge clk);
    a_in = 1'b0;
    run(4, ns, fs);
    $display("pulse4 rise steps=%0d pos=%0d dir=%0d", ns, position, dir);
    check("p4_rise_steps", ns, 1);
    check("p4_rise_pos", position, 13);
    check("p4_rise_dir", dir, 1);
    run(10, ns, fs);
    $display("pulse4 fall steps=%0d pos=%0d dir=%0d", ns, position, dir);
    check("p4_fall_steps", ns, 1);
    check("p4_fall_pos", position, 12);
    check("p4_fall_dir", dir, 0);

    // Illegal double transition 00->11.
    move(2'b11, 12, 0, 4'd12, "illegal");
    check("ill_err", err, 1);
    check("ill_dir", dir, 0);
    pulse_clear();
    check("ill_clr_err", err, 0);
    check("ill_clr_pos", position, 0);

    // Walk up from 11 to position 7.
    move(2'b01, 8, 1, 4'd1, "w1");
    move(2'b00, 8, 1, 4'd2, "w2");
    move(2'b10, 8, 1, 4'd3, "w3");
    move(2'b11, 8, 1, 4'd4, "w4");
    move(2'b01, 8, 1, 4'd5, "w5");
    move(2'b00, 8, 1, 4'd6, "w6");
    move(2'b10, 8, 1, 4'd7, "w7");

    // Reset mid-transition, away from any clock edge.
    a_in = 1'b1;
    b_in = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    $display("async reset step=%0d dir=%0d pos=%0d err=%0d", step, dir, position, err);
    check("ar_step", step, 0);
    check("ar_dir", dir, 1);
    check("ar_pos", position, 0);
    check("ar_err", err, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Inputs at 11 on release: absorbed silently during settle.
    run(30, ns, fs);
    $display("post reset steps=%0d pos=%0d err=%0d", ns, position, err);
    check("pr_steps", ns, 0);
    check("pr_err", err, 0);
    check("pr_pos", position, 0);
    move(2'b01, 10, 1, 4'd1, "pr_up");
    check("pr_up_dir", dir, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
